// File: rtl/vector_sweep_sequencer.sv
// Exhaustive input sweep for a small circuit under test: drives each vector in
// ascending order, waits SETTLE cycles, samples the response, emits a record.
module vector_sweep_sequencer #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_IN-1:0]  rec_vec,
  output logic [N_OUT-1:0] rec_resp,
  output logic             rec_last,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

  logic [1:0]       state;
  logic [N_IN-1:0]  vec;
  logic [7:0]       cnt;
  logic [N_OUT-1:0] resp;
  logic             vec_last;
  logic             handshake;

  // Record handshake: a record transfers on any rising edge where rec_valid
  // and rec_ready are both high; rec_vec/rec_resp/rec_last are held stable
  // while rec_valid is high and rec_ready is low.
  assign vec_last  = &vec;
  assign handshake = (state == S_EMIT) && rec_ready;

  always_ff @(posedge CK) begin
    if (reset) begin
      state <= S_IDLE;
      vec   <= '0;
      cnt   <= '0;
      resp  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec   <= '0;
            cnt   <= CNT_INIT;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            resp  <= dut_out;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          // The sweep stops at all-ones, so vec never wraps.
          if (handshake) begin
            if (vec_last) begin
              state <= S_DONE;
            end else begin
              vec   <= vec + N_IN'(1);
              cnt   <= CNT_INIT;
              state <= S_SETTLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode from state and registers only; dut_out reaches them via resp.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dut_in    = ((state == S_SETTLE) || (state == S_EMIT)) ? vec : '0;
  assign rec_valid = (state == S_EMIT);
  assign rec_vec   = (state == S_EMIT) ? vec : '0;
  assign rec_resp  = (state == S_EMIT) ? resp : '0;
  assign rec_last  = (state == S_EMIT) && vec_last;
  assign state_dbg = state;

endmodule

// File: tb/tb_vector_sweep_sequencer.sv
// Directed bench for vector_sweep_sequencer: three instances cover the basic
// sweep, a long settle with a delayed circuit model, and the one-bit width corner.
module tb_vector_sweep_sequencer;

  logic CK;
  logic reset;

  // Main instance: N_IN=2, SETTLE=1, dut_out = ^dut_in
  logic       start, rec_ready, busy, done, dut_out, rec_valid, rec_resp, rec_last;
  logic [1:0] dut_in, rec_vec, state_dbg;

  // Settle instance: N_IN=2, N_OUT=2, SETTLE=3, two registered delay stages
  logic       start3, rec_ready3, busy3, done3, rec_valid3, rec_last3;
  logic [1:0] dut_in3, dut_out3, rec_vec3, rec_resp3, state3, r1, r2;

  // Width corner: N_IN=1, SETTLE=255, dut_out = ~dut_in
  logic       start_w, rec_ready_w, busy_w, done_w, dut_in_w, dut_out_w;
  logic       rec_valid_w, rec_vec_w, rec_resp_w, rec_last_w;
  logic [1:0] state_w;

  int checks = 0;
  int errors = 0;

  initial CK = 1'b0;
  always #5 CK = ~CK;

  assign dut_out = ^dut_in;
  always @(posedge CK) begin
    r1 <= ~dut_in3;
    r2 <= r1;
  end
  assign dut_out3  = r2;
  assign dut_out_w = ~dut_in_w;

  vector_sweep_sequencer #(.N_IN(2), .N_OUT(1), .SETTLE(1)) u_dut (
    .CK(CK), .reset(reset), .start(start), .busy(busy), .done(done),
    .dut_in(dut_in), .dut_out(dut_out), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_vec(rec_vec), .rec_resp(rec_resp), .rec_last(rec_last), .state_dbg(state_dbg)
  );

  vector_sweep_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE(3)) u_dut3 (
    .CK(CK), .reset(reset), .start(start3), .busy(busy3), .done(done3),
    .dut_in(dut_in3), .dut_out(dut_out3), .rec_valid(rec_valid3), .rec_ready(rec_ready3),
    .rec_vec(rec_vec3), .rec_resp(rec_resp3), .rec_last(rec_last3), .state_dbg(state3)
  );

  vector_sweep_sequencer #(.N_IN(1), .N_OUT(1), .SETTLE(255)) u_dutw (
    .CK(CK), .reset(reset), .start(start_w), .busy(busy_w), .done(done_w),
    .dut_in(dut_in_w), .dut_out(dut_out_w), .rec_valid(rec_valid_w), .rec_ready(rec_ready_w),
    .rec_vec(rec_vec_w), .rec_resp(rec_resp_w), .rec_last(rec_last_w), .state_dbg(state_w)
  );

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, dut_in, rec_valid, rec_vec, rec_resp, rec_last, state_dbg} !== 10'd0) begin
      errors++;
      $display("FAIL reset_main got=%b exp=0", {busy, done, dut_in, rec_valid, rec_vec, rec_resp, rec_last, state_dbg});
    end
    checks++;
    if ({busy3, done3, dut_in3, rec_valid3, rec_vec3, rec_resp3, rec_last3,
         busy_w, done_w, dut_in_w, rec_valid_w, rec_vec_w, rec_resp_w, rec_last_w} !== 17'd0) begin
      errors++;
      $display("FAIL reset_others got nonzero outputs exp=0");
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle busy=%b state=%0d exp busy=0 state=0", busy, state_dbg);
    end
  endtask

  task automatic test_basic_sweep();
    int idx;
    logic exp_valid;
    logic [1:0] exp_din, v;
    rec_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      start = 1'b0;
      exp_valid = (cyc >= 2) && (cyc <= 8) && (cyc % 2 == 0);
      exp_din = (cyc <= 8) ? 2'((cyc - 1) / 2) : 2'd0;
      checks++;
      if (rec_valid !== exp_valid) begin
        errors++;
        $display("FAIL basic_valid cyc=%0d got=%b exp=%b", cyc, rec_valid, exp_valid);
      end
      checks++;
      if (dut_in !== exp_din) begin
        errors++;
        $display("FAIL basic_dut_in cyc=%0d got=%b exp=%b", cyc, dut_in, exp_din);
      end
      checks++;
      if (busy !== (cyc <= 9) || done !== (cyc == 9)) begin
        errors++;
        $display("FAIL basic_busy_done cyc=%0d got=%b%b exp=%b%b", cyc, busy, done, cyc <= 9, cyc == 9);
      end
      if (exp_valid) begin
        idx = (cyc - 2) / 2;
        v = 2'(idx);
        checks++;
        if (rec_vec !== v || rec_resp !== ^v || rec_last !== (idx == 3)) begin
          errors++;
          $display("FAIL basic_record cyc=%0d got=(%b,%b,last=%b) exp=(%b,%b,last=%b)",
                   cyc, rec_vec, rec_resp, rec_last, v, ^v, idx == 3);
        end
      end
    end
  endtask

  task automatic test_settle();
    logic exp_valid;
    logic [1:0] v;
    start3 = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      start3 = 1'b0;
      exp_valid = (cyc >= 4) && (cyc <= 16) && (cyc % 4 == 0);
      checks++;
      if (rec_valid3 !== exp_valid || done3 !== (cyc == 17)) begin
        errors++;
        $display("FAIL settle_timing cyc=%0d got valid=%b done=%b exp valid=%b done=%b",
                 cyc, rec_valid3, done3, exp_valid, cyc == 17);
      end
      if (exp_valid) begin
        v = 2'((cyc - 4) / 4);
        checks++;
        if (rec_vec3 !== v || rec_resp3 !== ~v) begin
          errors++;
          $display("FAIL settle_record cyc=%0d got=(%b,%b) exp=(%b,%b)", cyc, rec_vec3, rec_resp3, v, ~v);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_q[$];
    logic [2:0] exp_rec;
    logic [1:0] v;
    int held = 0;
    bit prev_hold = 1'b0;
    bit fin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      exp_q.push_back({v, ^v});
    end
    rec_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      tick();
      start = 1'b0;
      if (prev_hold) begin
        checks++;
        if (!(rec_valid === 1'b1 && rec_vec === 2'b01 && rec_resp === 1'b1 && dut_in === 2'b01)) begin
          errors++;
          $display("FAIL bp_hold cyc=%0d got valid=%b vec=%b resp=%b dut_in=%b exp 1,01,1,01",
                   cyc, rec_valid, rec_vec, rec_resp, dut_in);
        end
      end
      prev_hold = 1'b0;
      if (done === 1'b1) fin = 1'b1;
      rec_ready = 1'b1;
      if (rec_valid === 1'b1) begin
        if (rec_vec === 2'b01 && held < 5) begin
          rec_ready = 1'b0;
          held++;
          prev_hold = 1'b1;
        end else begin
          exp_rec = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
          checks++;
          if ({rec_vec, rec_resp} !== exp_rec || rec_last !== (rec_vec == 2'b11)) begin
            errors++;
            $display("FAIL bp_record cyc=%0d got=%b last=%b exp=%b", cyc, {rec_vec, rec_resp}, rec_last, exp_rec);
          end
        end
      end
    end
    rec_ready = 1'b1;
    checks++;
    if (!fin || exp_q.size() != 0 || held != 5) begin
      errors++;
      $display("FAIL bp_summary got done=%b left=%0d held=%0d exp done=1 left=0 held=5", fin, exp_q.size(), held);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int records = 0;
    int dones = 0;
    rec_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      start = (cyc == 1) || (cyc == 2) || (cyc == 9);
      if (cyc == 1 || cyc == 2 || cyc == 9) begin
        checks++;
        if (state_dbg !== ((cyc == 1) ? 2'd1 : (cyc == 2) ? 2'd2 : 2'd3)) begin
          errors++;
          $display("FAIL swb_state cyc=%0d got=%0d", cyc, state_dbg);
        end
      end
      if (rec_valid === 1'b1) begin
        checks++;
        if (rec_vec !== 2'(records)) begin
          errors++;
          $display("FAIL swb_order cyc=%0d got=%b exp=%b", cyc, rec_vec, 2'(records));
        end
        records++;
      end
      if (done === 1'b1) dones++;
      if (cyc >= 10) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL swb_idle cyc=%0d got busy=%b exp=0", cyc, busy);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (records != 4 || dones != 1) begin
      errors++;
      $display("FAIL swb_count got records=%0d dones=%0d exp 4 1", records, dones);
    end
  endtask

  task automatic test_back_to_back();
    int records = 0;
    int dones = 0;
    bit restart_now = 1'b0;
    bit armed = 1'b0;
    rec_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 40 && dones < 2; cyc++) begin
      tick();
      start = 1'b0;
      if (armed) begin
        armed = 1'b0;
        checks++;
        if (busy !== 1'b1 || state_dbg !== 2'd1) begin
          errors++;
          $display("FAIL b2b_restart cyc=%0d got busy=%b state=%0d exp 1 1", cyc, busy, state_dbg);
        end
      end
      if (restart_now) begin
        restart_now = 1'b0;
        armed = 1'b1;
        start = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle cyc=%0d got busy=%b exp=0", cyc, busy);
        end
      end
      if (rec_valid === 1'b1) begin
        checks++;
        if (rec_vec !== 2'(records % 4)) begin
          errors++;
          $display("FAIL b2b_order cyc=%0d got=%b exp=%b", cyc, rec_vec, 2'(records % 4));
        end
        records++;
      end
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) restart_now = 1'b1;
      end
    end
    checks++;
    if (records != 8 || dones != 2) begin
      errors++;
      $display("FAIL b2b_count got records=%0d dones=%0d exp 8 2", records, dones);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    bit fin = 1'b0;
    rec_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
      tick();
      start = 1'b0;
      if (rec_valid === 1'b1 && rec_vec === 2'b10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_reach got no EMIT for vector 10 within 20 cycles");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, dut_in, rec_valid, rec_vec, rec_resp, rec_last, state_dbg} !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b exp=0", {busy, done, dut_in, rec_valid, rec_vec, rec_resp, rec_last, state_dbg});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (rec_valid !== 1'b1 || rec_vec !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_restart got valid=%b vec=%b exp 1 00", rec_valid, rec_vec);
    end
    for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
      tick();
      if (done === 1'b1) fin = 1'b1;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL rst_mid_finish got no done within 20 cycles");
    end
    tick();
  endtask

  task automatic test_width_corner();
    logic exp_valid;
    logic v;
    start_w = 1'b1;
    for (int cyc = 1; cyc <= 514; cyc++) begin
      tick();
      start_w = 1'b0;
      exp_valid = (cyc == 256) || (cyc == 512);
      checks++;
      if (rec_valid_w !== exp_valid || done_w !== (cyc == 513) || busy_w !== (cyc <= 513)) begin
        errors++;
        $display("FAIL width_timing cyc=%0d got valid=%b done=%b busy=%b exp %b %b %b",
                 cyc, rec_valid_w, done_w, busy_w, exp_valid, cyc == 513, cyc <= 513);
      end
      if (exp_valid) begin
        v = (cyc == 512);
        checks++;
        if (rec_vec_w !== v || rec_resp_w !== ~v || rec_last_w !== v) begin
          errors++;
          $display("FAIL width_record cyc=%0d got=(%b,%b,last=%b) exp=(%b,%b,last=%b)",
                   cyc, rec_vec_w, rec_resp_w, rec_last_w, v, ~v, v);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    start_w = 1'b0;
    rec_ready = 1'b1;
    rec_ready3 = 1'b1;
    rec_ready_w = 1'b1;
    test_reset();
    test_basic_sweep();
    test_settle();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_sweep();
    test_width_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
